// File: rtl/operand_skew_buffer.sv
// operand_skew_buffer
//
// Captures one N x N operand block row by row, then replays it to the PE
// array as a diagonally skewed stream. Lane i carries buffer row i and is
// delayed by i beats, so lane i at beat t shows element [i][t-i]. Lanes
// outside their window show zero. The input-mux controller can force
// individual lanes of a beat to zero through mux_reset.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous, active-low reset (0 = reset)
//   in_valid    in_row holds a valid operand row
//   in_ready    a row can be accepted this cycle (IDLE or LOAD)
//   in_row      one block row, element j at [j*DATA_W +: DATA_W]
//   mux_reset   per-lane zero-force, honoured only while streaming
//   out_data    skewed lane outputs, lane i at [i*DATA_W +: DATA_W]
//   out_valid   out_data is a valid stream beat
//   busy        state is not IDLE
//   block_done  one-cycle pulse after the last stream beat

module operand_skew_buffer #(
    parameter int DATA_W = 8,
    parameter int N      = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_row,
    input  logic [N-1:0]        mux_reset,
    output logic [N*DATA_W-1:0] out_data,
    output logic                out_valid,
    output logic                busy,
    output logic                block_done
);

    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
    localparam int T_W   = $clog2(2 * N);

    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(N - 1);
    localparam logic [T_W-1:0]   LAST_BEAT = T_W'(2 * N - 2);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [ROW_W-1:0]  row_cnt;
    logic [T_W-1:0]    beat_cnt;
    logic [DATA_W-1:0] row_buf [N][N];

    logic              accept;
    logic              last_row;
    logic              last_beat;
    logic [N*DATA_W-1:0] beat_data;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the two combinational outputs. A row is
    // accepted whenever the block is loading and the producer offers one;
    // the row that fills the last buffer slot starts the stream.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        last_row   = (row_cnt == LAST_ROW);
        last_beat  = (beat_cnt == LAST_BEAT);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = last_row ? STREAM : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (last_row) begin
                        next_state = STREAM;
                    end
                end
            end
            STREAM: begin
                if (last_beat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Row and beat counters. The row counter returns to zero when the block
    // is full so the next block starts at row 0; the beat counter is armed
    // by that same final row.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_cnt  <= '0;
            beat_cnt <= '0;
        end else begin
            if (accept) begin
                row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            end
            if (accept && last_row) begin
                beat_cnt <= '0;
            end else if (state == STREAM) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Operand bank, written one full row per accepted transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    row_buf[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int c = 0; c < N; c++) begin
                row_buf[row_cnt][c] <= in_row[c*DATA_W +: DATA_W];
            end
        end
    end

    // Skew selection: lane i shows column c of its row when t == i + c.
    // Lanes outside their window, or forced by mux_reset, stay zero.
    always_comb begin
        beat_data = '0;
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++) begin
                if ((int'(beat_cnt) == i + c) && !mux_reset[i]) begin
                    beat_data[i*DATA_W +: DATA_W] = row_buf[i][c];
                end
            end
        end
    end

    // Registered stream outputs. DONE emits the completion pulse and blanks
    // the data; every other non-stream state holds the outputs quiet.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            block_done <= 1'b0;
        end else begin
            case (state)
                STREAM: begin
                    out_data   <= beat_data;
                    out_valid  <= 1'b1;
                    block_done <= 1'b0;
                end
                DONE: begin
                    out_data   <= '0;
                    out_valid  <= 1'b0;
                    block_done <= 1'b1;
                end
                default: begin
                    out_data   <= '0;
                    out_valid  <= 1'b0;
                    block_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/operand_skew_buffer.md
Name: operand_skew_buffer

Overview:
- Downstream consumer of the input-mux controller's `mux_reset[3:0]` vector in the matrix block multiplier.
- Captures one N×N operand block, row by row, into a register bank.
- Replays the block to the PE array as a diagonally skewed stream: lane i delayed i cycles.
- Per-lane `mux_reset` bits force individual lane outputs to zero.

Parameters:
- DATA_W, 8, bit width of one matrix element.
- N, 4, block dimension and lane count; `mux_reset` width equals N.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  `in_row` holds a valid operand row.
- in_ready  output  1  block can accept a row this cycle.
- in_row  input  N*DATA_W  one block row; element j at bits [j*DATA_W +: DATA_W].
- mux_reset  input  N  per-lane zero-force from the input-mux controller.
- out_data  output  N*DATA_W  skewed lane outputs; lane i at bits [i*DATA_W +: DATA_W].
- out_valid  output  1  `out_data` is a valid stream beat.
- busy  output  1  high when the state is not IDLE.
- block_done  output  1  one-cycle pulse after the last stream beat.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; row counter and beat counter cleared.
  - Buffer cleared to 0.
  - Outputs: `out_data`=0, `out_valid`=0, `block_done`=0, `busy`=0.
  - `in_ready`=1 as soon as reset deasserts.
- States: IDLE, LOAD, STREAM, DONE. All outputs are registered except `in_ready` and `busy`, which decode the state combinationally.
- IDLE/LOAD:
  - `in_ready`=1.
  - A row is accepted on a rising edge with `in_valid`=1. It is stored as buffer row r=row_cnt, then row_cnt increments.
  - The first accepted row moves IDLE→LOAD.
  - Accepting row N-1 moves to STREAM and clears the beat counter t.
  - `in_valid`=0 cycles stall the load indefinitely; there is no timeout.
- STREAM:
  - `in_ready`=0; `in_valid` is ignored and no buffer write occurs.
  - Each edge registers one beat: lane i = buf[i][t-i] if 0 ≤ t-i < N, else 0. Then t increments.
  - `out_valid`=1 for exactly 2N-1 consecutive beats (t=0..2N-2).
  - After the beat with t=2N-2 is registered, state→DONE.
- mux_reset:
  - Sampled on the same edge that registers the beat.
  - `mux_reset[i]`=1 forces lane i of that beat to 0; other lanes are unaffected.
  - Ignored outside STREAM.
  - Does not alter buffer contents or counters.
- DONE (one cycle):
  - The next edge sets `out_valid`=0, `out_data`=0, `block_done`=1 and state→IDLE.
  - `block_done` clears on the following edge.
- Back-to-back blocks: a row presented in the cycle `block_done`=1 (state IDLE, `in_ready`=1) is accepted as row 0 of the next block.
- Latency: last row accepted on edge E → first beat visible after E+1 → last beat after E+2N-1 → `block_done` after E+2N.
- Reset mid-operation: immediate abort; partial rows and the in-flight stream are discarded; no `block_done` is produced.
- Arithmetic: no arithmetic on data; elements pass through unmodified.
  - row_cnt width: clog2(N).
  - t width: clog2(2N).
  - Counters never wrap within a block.

Test Plan (N=4, DATA_W=8; A rows = [1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16]):
- Load A with `in_valid` held high, `mux_reset`=0 → 7 beats (lane0..lane3):
  - t0=(1,0,0,0), t1=(2,5,0,0), t3=(4,7,10,13), t6=(0,0,0,16).
  - `block_done` pulses the cycle after t6.
- Load A with `in_valid` toggling 1,0,1,0... → rows stored in order only on valid edges; stream identical to the previous test; `in_ready`=0 throughout STREAM.
- `mux_reset`=4'b0010 during beat t3 only → t3=(4,0,10,13); t4=(0,8,11,14) unaffected.
- Drive reset=0 at beat t2, release 2 cycles later → `out_valid`=0 and `busy`=0 immediately, no `block_done`; reloading A gives the full correct stream.
- Present block B (all elements 0xFF) starting in the `block_done` cycle of block A → B row 0 accepted then; B stream beat t3=(FF,FF,FF,FF).
- Assert `in_valid` with row 0x55 during STREAM → ignored; the next block loads normally and stream values are unchanged.
